// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from 1-bit full-adder cells, with a
// zero-latency combinational result and a one-cycle registered result.
//
// Parameters
//   WIDTH      operand and sum width in bits (1..64)
//   SIGNED_OVF 1 enables the registered signed-overflow flag, 0 ties it low
//
// Ports
//   clk       rising-edge clock for the registered path
//   rst       asynchronous, active-high reset of the registered path
//   a, b      operands
//   cin       carry in
//   in_valid  qualifies a/b/cin for capture
//   sum       combinational (a + b + cin) mod 2^WIDTH
//   carry     combinational carry out of the MSB
//   sum_q     registered sum
//   carry_q   registered carry
//   ovf_q     registered signed overflow
//   out_valid high for one cycle per captured operation
module full_adder #(
    parameter int unsigned WIDTH      = 1,
    parameter bit          SIGNED_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[0] = cin, c[WIDTH] = carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf;

    // Ripple chain: one full-adder cell per bit.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign sum   = s;
    assign carry = c[WIDTH];

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf = (c[WIDTH] ^ c[WIDTH-1]) & SIGNED_OVF;

    // Registered path
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;
    logic             out_valid_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_r_q;
    logic             carry_r_q;
    logic             ovf_r_q;

    // Results hold when nothing is captured; only the valid flag drops.
    always_comb begin
        sum_d       = sum_r_q;
        carry_d     = carry_r_q;
        ovf_d       = ovf_r_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d   = s;
            carry_d = c[WIDTH];
            ovf_d   = ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r_q     <= '0;
            carry_r_q   <= 1'b0;
            ovf_r_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_r_q     <= sum_d;
            carry_r_q   <= carry_d;
            ovf_r_q     <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum_q     = sum_r_q;
    assign carry_q   = carry_r_q;
    assign ovf_q     = ovf_r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a 1-bit instance, an 8-bit instance with
// overflow enabled and an 8-bit instance with overflow disabled.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, v1 = 1'b0;
    logic       sum1, carry1, sum_q1, carry_q1, ovf_q1, ov1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0, v8 = 1'b0;
    logic [7:0] sum8, sum_q8, sum8n, sum_q8n;
    logic       carry8, carry_q8, ovf_q8, ov8;
    logic       carry8n, carry_q8n, ovf_q8n, ov8n;

    int compared   = 0;
    int mismatched = 0;

    // Hand-written WIDTH=1 truth table, indexed by {a,b,cin}.
    logic [7:0] sum_tab   = 8'b1001_0110;
    logic [7:0] carry_tab = 8'b1110_1000;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .SIGNED_OVF(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
        .ovf_q(ovf_q1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8), .SIGNED_OVF(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .ovf_q(ovf_q8), .out_valid(ov8)
    );

    full_adder #(.WIDTH(8), .SIGNED_OVF(1'b0)) u_dut8n (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
        .sum(sum8n), .carry(carry8n), .sum_q(sum_q8n), .carry_q(carry_q8n),
        .ovf_q(ovf_q8n), .out_valid(ov8n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Drive an 8-bit vector, check comb outputs, capture, check registered.
    task automatic vec8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] e_sum, input logic e_carry, input logic e_ovf);
        a8 = a; b8 = b; cin8 = ci; v8 = 1'b1;
        #1;
        check("w8 sum", 64'(sum8), 64'(e_sum));
        check("w8 carry", 64'(carry8), 64'(e_carry));
        check("w8n sum", 64'(sum8n), 64'(e_sum));
        next_edge();
        check("w8 sum_q", 64'(sum_q8), 64'(e_sum));
        check("w8 carry_q", 64'(carry_q8), 64'(e_carry));
        check("w8 ovf_q", 64'(ovf_q8), 64'(e_ovf));
        check("w8 out_valid", 64'(ov8), 64'd1);
        check("w8n ovf_q", 64'(ovf_q8n), 64'd0);
        check("w8n carry_q", 64'(carry_q8n), 64'(e_carry));
    endtask

    initial begin
        // Reset values, no clock edge yet.
        #3;
        check("rst sum_q", 64'(sum_q1), 64'd0);
        check("rst carry_q", 64'(carry_q1), 64'd0);
        check("rst ovf_q", 64'(ovf_q1), 64'd0);
        check("rst out_valid", 64'(ov1), 64'd0);
        check("rst w8 sum_q", 64'(sum_q8), 64'd0);

        // Exhaustive WIDTH=1 truth table, combinational (works during reset).
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            #1;
            check($sformatf("tt sum %0d", i), 64'(sum1), 64'(sum_tab[i]));
            check($sformatf("tt carry %0d", i), 64'(carry1), 64'(carry_tab[i]));
            #9;
        end

        @(negedge clk);
        rst = 1'b0;

        // Single capture then hold.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; v1 = 1'b1;
        next_edge();
        check("reg sum_q", 64'(sum_q1), 64'd0);
        check("reg carry_q", 64'(carry_q1), 64'd1);
        check("reg ovf_q", 64'(ovf_q1), 64'd1);
        check("reg out_valid", 64'(ov1), 64'd1);
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
        next_edge();
        check("hold out_valid", 64'(ov1), 64'd0);
        check("hold sum_q", 64'(sum_q1), 64'd0);
        check("hold carry_q", 64'(carry_q1), 64'd1);
        check("hold ovf_q", 64'(ovf_q1), 64'd1);

        // WIDTH=8 boundaries, overflow on and off.
        vec8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        vec8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        vec8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        vec8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);
        v8 = 1'b0;
        next_edge();
        check("w8 out_valid drop", 64'(ov8), 64'd0);
        check("w8 sum_q held", 64'(sum_q8), 64'h4C);

        // Async reset between edges discards the captured result.
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
        next_edge();
        check("pre-rst sum_q", 64'(sum_q1), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async sum_q", 64'(sum_q1), 64'd0);
        check("async carry_q", 64'(carry_q1), 64'd0);
        check("async ovf_q", 64'(ovf_q1), 64'd0);
        check("async out_valid", 64'(ov1), 64'd0);
        check("async w8 sum_q", 64'(sum_q8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; v1 = 1'b1;
        next_edge();
        check("post-rst sum_q", 64'(sum_q1), 64'd0);
        check("post-rst carry_q", 64'(carry_q1), 64'd1);
        check("post-rst ovf_q", 64'(ovf_q1), 64'd0);
        check("post-rst out_valid", 64'(ov1), 64'd1);

        // Back-to-back stream of 8 valid vectors.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            v1 = 1'b1;
            next_edge();
            check($sformatf("b2b sum_q %0d", i), 64'(sum_q1), 64'(sum_tab[i]));
            check($sformatf("b2b carry_q %0d", i), 64'(carry_q1), 64'(carry_tab[i]));
            check($sformatf("b2b ovf_q %0d", i), 64'(ovf_q1), 64'(carry_tab[i] ^ i[0]));
            check($sformatf("b2b out_valid %0d", i), 64'(ov1), 64'd1);
        end
        v1 = 1'b0;
        next_edge();
        check("b2b out_valid end", 64'(ov1), 64'd0);
        check("b2b sum_q held", 64'(sum_q1), 64'(sum_tab[7]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
